nonce_sweep_ctrl: RTL and testbench

NONCE_SWEEP_CTRL -- requirements
Module: nonce_sweep_ctrl

---
 rtl/nonce_sweep_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_nonce_sweep_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweep_ctrl.sv
// Purpose: sweeps an inclusive nonce range over NUM_CORES external hash cores and reports the lowest nonce whose hash is strictly below target.
// Latency: core_start rises one cycle after an accepted start; each batch costs one DISPATCH, a WAIT as long as the slowest launched core, and one EVAL.
// Backpressure: none; pacing comes only from the per-core done pulses. abort overrides every transition. Optional NONCE_SWEEP_HASH_COUNT_EN adds hash_count.
module nonce_sweep_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NONCE_W-1:0]             nonce_base,
  input  logic [NONCE_W-1:0]             nonce_limit,
  input  logic [255:0]                   target,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES*256-1:0]       core_hash,
  output logic                           busy,
  output logic                           hashSuccess,
  output logic                           exhausted,
  output logic [NONCE_W-1:0]             found_nonce,
  output logic [255:0]                   satisfactoryHash,
  output logic                           ledControl
`ifdef NONCE_SWEEP_HASH_COUNT_EN
  ,
  output logic [47:0]                    hash_count
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DISPATCH  = 3'd1;
  localparam logic [2:0] S_WAIT      = 3'd2;
  localparam logic [2:0] S_EVAL      = 3'd3;
  localparam logic [2:0] S_FOUND     = 3'd4;
  localparam logic [2:0] S_EXHAUSTED = 3'd5;

  logic [2:0]                   state_q, state_d;
  logic [NONCE_W-1:0]           limit_q, limit_d;
  logic [NONCE_W-1:0]           next_q, next_d;
  logic [255:0]                 target_q, target_d;
  logic [NUM_CORES-1:0]         mask_q, mask_d;
  logic [NUM_CORES-1:0]         done_q, done_d;
  logic [NUM_CORES-1:0]         core_start_q, core_start_d;
  logic [NUM_CORES*NONCE_W-1:0] core_nonce_q, core_nonce_d;
  logic [255:0]                 hash_q [NUM_CORES];
  logic [255:0]                 hash_d [NUM_CORES];
  logic [NONCE_W-1:0]           found_q, found_d;
  logic [255:0]                 sat_q, sat_d;
  logic                         led_q, led_d;

  // Start of the following batch; the extra top bit catches NONCE_W overflow,
  // which must end the sweep rather than wrap around to nonce 0.
  logic [NONCE_W:0] step_sum;
  logic             step_ok;
  always_comb begin
    step_sum = {1'b0, next_q} + (NONCE_W+1)'(NUM_CORES);
    step_ok  = !step_sum[NONCE_W] && (step_sum[NONCE_W-1:0] <= limit_q);
  end

  // Launch plan for the batch entered on this edge: from EVAL it is the next
  // batch against the latched limit, otherwise a fresh sweep from the ports.
  logic [NONCE_W-1:0]           disp_base, disp_limit;
  logic [NONCE_W:0]             lane_sum;
  logic [NUM_CORES-1:0]         launch_mask;
  logic [NUM_CORES*NONCE_W-1:0] launch_nonce;
  always_comb begin
    if (state_q == S_EVAL) begin
      disp_base  = step_sum[NONCE_W-1:0];
      disp_limit = limit_q;
    end else begin
      disp_base  = nonce_base;
      disp_limit = nonce_limit;
    end
    lane_sum     = '0;
    launch_mask  = '0;
    launch_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      lane_sum = {1'b0, disp_base} + (NONCE_W+1)'(i);
      launch_mask[i] = !lane_sum[NONCE_W] && (lane_sum[NONCE_W-1:0] <= disp_limit);
      launch_nonce[i*NONCE_W +: NONCE_W] = lane_sum[NONCE_W-1:0];
    end
  end

  // Accepted completions: only in WAIT, only launched cores, only once per core.
  logic [NUM_CORES-1:0] take;
  logic                 all_done;
  always_comb begin
    take     = (state_q == S_WAIT) ? (core_done & mask_q & ~done_q) : '0;
    all_done = (((done_q | take) & mask_q) == mask_q);
  end

  // Lowest-index launched core with a hash strictly below target wins.
  logic               any_hit;
  logic [NONCE_W-1:0] win_nonce;
  logic [255:0]       win_hash;
  always_comb begin
    any_hit   = 1'b0;
    win_nonce = '0;
    win_hash  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!any_hit && mask_q[i] && (hash_q[i] < target_q)) begin
        any_hit   = 1'b1;
        win_nonce = core_nonce_q[i*NONCE_W +: NONCE_W];
        win_hash  = hash_q[i];
      end
    end
  end

  // A start is honoured only when no sweep is running and abort is low.
  logic accept_start;
  always_comb begin
    accept_start = start && !abort &&
                   ((state_q == S_IDLE) || (state_q == S_FOUND) || (state_q == S_EXHAUSTED));
  end

  // Sweep sequencing: abort is applied last so it overrides start and every transition.
  always_comb begin
    state_d      = state_q;
    limit_d      = limit_q;
    target_d     = target_q;
    next_d       = next_q;
    mask_d       = mask_q;
    done_d       = done_q | take;
    core_start_d = '0;
    core_nonce_d = core_nonce_q;
    found_d      = found_q;
    sat_d        = sat_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      hash_d[i] = hash_q[i];
      if (take[i]) begin
        hash_d[i] = core_hash[i*256 +: 256];
      end
    end

    case (state_q)
      S_DISPATCH: state_d = S_WAIT;
      S_WAIT: begin
        if (all_done) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (any_hit) begin
          state_d = S_FOUND;
          found_d = win_nonce;
          sat_d   = win_hash;
        end else if (step_ok) begin
          state_d      = S_DISPATCH;
          next_d       = step_sum[NONCE_W-1:0];
          mask_d       = launch_mask;
          done_d       = '0;
          core_start_d = launch_mask;
          core_nonce_d = launch_nonce;
        end else begin
          state_d = S_EXHAUSTED;
        end
      end
      default: ;
    endcase

    if (accept_start) begin
      limit_d  = nonce_limit;
      target_d = target;
      next_d   = nonce_base;
      found_d  = '0;
      sat_d    = '0;
      done_d   = '0;
      if (nonce_base > nonce_limit) begin
        state_d = S_EXHAUSTED;
        mask_d  = '0;
      end else begin
        state_d      = S_DISPATCH;
        mask_d       = launch_mask;
        core_start_d = launch_mask;
        core_nonce_d = launch_nonce;
      end
    end

    if (abort) begin
      state_d      = S_IDLE;
      mask_d       = '0;
      done_d       = '0;
      core_start_d = '0;
      core_nonce_d = '0;
      found_d      = '0;
      sat_d        = '0;
    end

    // ledControl mirrors hashSuccess exactly but comes straight from a flop.
    led_d = (state_d == S_FOUND);
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      limit_q      <= '0;
      next_q       <= '0;
      target_q     <= '0;
      mask_q       <= '0;
      done_q       <= '0;
      core_start_q <= '0;
      core_nonce_q <= '0;
      found_q      <= '0;
      sat_q        <= '0;
      led_q        <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        hash_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      limit_q      <= limit_d;
      next_q       <= next_d;
      target_q     <= target_d;
      mask_q       <= mask_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
      core_nonce_q <= core_nonce_d;
      found_q      <= found_d;
      sat_q        <= sat_d;
      led_q        <= led_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        hash_q[i] <= hash_d[i];
      end
    end
  end

`ifdef NONCE_SWEEP_HASH_COUNT_EN
  logic [47:0] cnt_q, cnt_d;
  logic [47:0] take_cnt;
  logic [48:0] cnt_sum;

  // Hashes accepted this sweep: adds the number of completions taken this cycle, saturating.
  always_comb begin
    take_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      take_cnt = take_cnt + 48'(take[i]);
    end
    cnt_sum = {1'b0, cnt_q} + {1'b0, take_cnt};
    cnt_d   = cnt_sum[48] ? '1 : cnt_sum[47:0];
    if (accept_start) begin
      cnt_d = '0;
    end
  end

  // Hash counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hash_count = cnt_q;
`endif

  assign core_start       = core_start_q;
  assign core_nonce       = core_nonce_q;
  assign busy             = (state_q == S_DISPATCH) || (state_q == S_WAIT) || (state_q == S_EVAL);
  assign hashSuccess      = (state_q == S_FOUND);
  assign exhausted        = (state_q == S_EXHAUSTED);
  assign found_nonce      = found_q;
  assign satisfactoryHash = sat_q;
  assign ledControl       = led_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: directed and random sweeps against a range-level reference model.
// Hash cores are modelled with programmable latency; a core's hash is derived from its nonce and the hit/equal tables.
// The optional hash_count port is connected and checked when NONCE_SWEEP_HASH_COUNT_EN is defined.
module tb_nonce_sweep_ctrl;
  localparam int NC = 4;
  localparam int NW = 32;

  logic              clock = 1'b0;
  logic              reset, start, abort;
  logic [NW-1:0]     nonce_base, nonce_limit;
  logic [255:0]      target;
  logic [NC-1:0]     core_start, core_done;
  logic [NC*NW-1:0]  core_nonce;
  logic [NC*256-1:0] core_hash;
  logic              busy, hashSuccess, exhausted, ledControl;
  logic [NW-1:0]     found_nonce;
  logic [255:0]      satisfactoryHash;
`ifdef NONCE_SWEEP_HASH_COUNT_EN
  logic [47:0]       hash_count;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [255:0] cur_tgt;
  logic [31:0] hits[$];
  logic [31:0] eqs[$];
  logic [31:0] exp_launch[$];
  int          launches_seen;
  int          lat_cfg[NC];
  bit          stray_ok;
  logic [NC-1:0] pend;
  int          cnt[NC];
  logic [31:0] pn[NC];

  nonce_sweep_ctrl #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .nonce_base(nonce_base), .nonce_limit(nonce_limit), .target(target),
    .core_start(core_start), .core_nonce(core_nonce),
    .core_done(core_done), .core_hash(core_hash),
    .busy(busy), .hashSuccess(hashSuccess), .exhausted(exhausted),
    .found_nonce(found_nonce), .satisfactoryHash(satisfactoryHash),
    .ledControl(ledControl)
`ifdef NONCE_SWEEP_HASH_COUNT_EN
    , .hash_count(hash_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  function automatic bit in_q(input logic [31:0] q[$], input logic [31:0] n);
    foreach (q[k]) if (q[k] == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [255:0] hash_fn(input logic [31:0] n);
    if (in_q(hits, n)) return cur_tgt - 256'(n[7:0]) - 256'd1;
    if (in_q(eqs, n)) return cur_tgt;
    return cur_tgt + 256'(n) + 256'd1;
  endfunction

  function automatic logic [255:0] new_target();
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
    t[255:252] = 4'h4;
    return t;
  endfunction

  // Reference: the sweep visits nonces base..limit in batches of NC; the first
  // batch containing a hitting nonce ends it, and the smallest such nonce wins.
  task automatic model(input logic [31:0] b, input logic [31:0] l, output bit fnd,
                       output logic [31:0] fn, output int nl, output logic [NC-1:0] fm);
    longint unsigned g, n;
    fnd = 1'b0; fn = '0; nl = 0; fm = '0;
    exp_launch.delete();
    if (b <= l) begin
      g = {32'd0, b};
      for (int k = 0; k < NC; k++) if (g + longint'(k) <= {32'd0, l}) fm[k] = 1'b1;
      while (!fnd && g <= {32'd0, l}) begin
        for (int k = 0; k < NC; k++) begin
          n = g + longint'(k);
          if (n <= {32'd0, l}) begin
            exp_launch.push_back(n[31:0]);
            nl++;
            if (!fnd && in_q(hits, n[31:0])) begin
              fnd = 1'b1;
              fn = n[31:0];
            end
          end
        end
        g += NC;
      end
    end
  endtask

  // Hash core model: launch on core_start, reply core_done after a per-core latency.
  initial begin
    pend = '0;
    core_done = '0;
    core_hash = '0;
    forever begin
      @(negedge clock);
      core_done = '0;
      for (int i = 0; i < NC; i++) begin
        if (pend[i]) begin
          if (cnt[i] <= 1) begin
            core_done[i] = 1'b1;
            core_hash[i*256 +: 256] = hash_fn(pn[i]);
            pend[i] = 1'b0;
            if (!stray_ok) chk("nonce_stable", 256'(core_nonce[i*NW +: NW]), 256'(pn[i]));
          end else begin
            cnt[i]--;
          end
        end
        if (core_start[i] === 1'b1) begin
          pend[i] = 1'b1;
          cnt[i] = (lat_cfg[i] > 0) ? lat_cfg[i] : int'($urandom_range(6, 1));
          pn[i] = core_nonce[i*NW +: NW];
          launches_seen++;
          if (exp_launch.size() > 0) chk("launch_nonce", 256'(pn[i]), 256'(exp_launch.pop_front()));
          else chk("launch_extra", 256'(core_start[i]), 256'd0);
        end
      end
    end
  end

  task automatic run_sweep(input string nm, input logic [31:0] b, input logic [31:0] l, input bit poke);
    bit fnd, ended;
    logic [31:0] fn;
    int nl;
    logic [NC-1:0] fm;
    model(b, l, fnd, fn, nl, fm);
    launches_seen = 0;
    @(negedge clock);
    start = 1'b1; nonce_base = b; nonce_limit = l; target = cur_tgt;
    @(negedge clock);
    start = 1'b0; nonce_base = $urandom; nonce_limit = $urandom; target = ~cur_tgt;
    chk({nm, ":start_mask"}, 256'(core_start), 256'(fm));
    chk({nm, ":cleared"}, 256'({hashSuccess, ledControl, found_nonce, satisfactoryHash[31:0]}), 256'd0);
    chk({nm, ":busy_early"}, 256'(busy), 256'(b <= l));
    chk({nm, ":exh_early"}, 256'(exhausted), 256'(b > l));
    if (poke) begin
      @(negedge clock); start = 1'b1; nonce_base = 32'h0; nonce_limit = 32'hffff_ffff;
      @(negedge clock); start = 1'b0;
    end
    ended = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (hashSuccess || exhausted) begin
        ended = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk({nm, ":timeout"}, 256'(ended), 256'd1);
    chk({nm, ":hashSuccess"}, 256'(hashSuccess), 256'(fnd));
    chk({nm, ":exhausted"}, 256'(exhausted), 256'(!fnd));
    chk({nm, ":busy_end"}, 256'(busy), 256'd0);
    chk({nm, ":ledControl"}, 256'(ledControl), 256'(fnd));
    chk({nm, ":found_nonce"}, 256'(found_nonce), fnd ? 256'(fn) : 256'd0);
    chk({nm, ":satHash"}, satisfactoryHash, fnd ? hash_fn(fn) : 256'd0);
    chk({nm, ":launches"}, 256'(launches_seen), 256'(nl));
    chk({nm, ":missing_launch"}, 256'(exp_launch.size()), 256'd0);
`ifdef NONCE_SWEEP_HASH_COUNT_EN
    chk({nm, ":hash_count"}, 256'(hash_count), 256'(nl));
`endif
    repeat (3) @(negedge clock);
    chk({nm, ":hold"}, 256'({hashSuccess, exhausted, ledControl}), 256'({fnd, !fnd, fnd}));
  endtask

  initial begin
    logic [31:0] b, l, len;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    nonce_base = '0; nonce_limit = '0; target = '0;
    stray_ok = 1'b0;
    for (int i = 0; i < NC; i++) lat_cfg[i] = 0;
    cur_tgt = new_target();

    repeat (3) @(negedge clock);
    chk("rst:core_start", 256'(core_start), 256'd0);
    chk("rst:busy", 256'(busy), 256'd0);
    chk("rst:hashSuccess", 256'(hashSuccess), 256'd0);
    chk("rst:exhausted", 256'(exhausted), 256'd0);
    chk("rst:ledControl", 256'(ledControl), 256'd0);
    chk("rst:found_nonce", 256'(found_nonce), 256'd0);
    chk("rst:satHash", satisfactoryHash, 256'd0);
    chk("rst:core_nonce", 256'(core_nonce), 256'd0);
`ifdef NONCE_SWEEP_HASH_COUNT_EN
    chk("rst:hash_count", 256'(hash_count), 256'd0);
`endif
    reset = 1'b0;
    @(negedge clock);
    chk("idle:busy", 256'({busy, hashSuccess, exhausted}), 256'd0);

    hits.push_back(32'h42a1_4695);
    run_sweep("single_hit", 32'h42a1_4690, 32'h42a1_46ff, 1'b1);

    hits.delete();
    run_sweep("short_range", 32'h10, 32'h12, 1'b0);
    run_sweep("top_of_range", 32'hffff_fffe, 32'hffff_ffff, 1'b0);

    hits.push_back(32'h1001); hits.push_back(32'h1003);
    lat_cfg[0] = 2; lat_cfg[1] = 6; lat_cfg[2] = 2; lat_cfg[3] = 1;
    run_sweep("two_hits", 32'h1000, 32'h1003, 1'b0);
    for (int i = 0; i < NC; i++) lat_cfg[i] = 0;

    hits.delete();
    for (int k = 0; k < 8; k++) eqs.push_back(32'h2000 + k);
    run_sweep("equal_target", 32'h2000, 32'h2007, 1'b0);
    eqs.delete();

    hits.push_back(32'h3008); eqs.push_back(32'h3004);
    run_sweep("eq_then_hit", 32'h3000, 32'h300f, 1'b0);
    hits.delete(); eqs.delete();

    run_sweep("base_gt_limit", 32'h500, 32'h4ff, 1'b0);

    // Abort in WAIT with slow cores, so their done pulses land while idle.
    for (int i = 0; i < NC; i++) lat_cfg[i] = 5;
    exp_launch.delete();
    for (int k = 0; k < NC; k++) exp_launch.push_back(32'h7000 + k);
    launches_seen = 0;
    stray_ok = 1'b1;
    @(negedge clock); start = 1'b1; nonce_base = 32'h7000; nonce_limit = 32'h70ff; target = cur_tgt;
    @(negedge clock); start = 1'b0;
    @(negedge clock); abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    chk("abort:outputs", 256'({busy, hashSuccess, exhausted, ledControl, core_start}), 256'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("abort:stray", 256'({busy, hashSuccess, exhausted, ledControl, core_start, found_nonce}), 256'd0);
    end
    chk("abort:launches", 256'(launches_seen), 256'd4);
    stray_ok = 1'b0;
    for (int i = 0; i < NC; i++) lat_cfg[i] = 0;

    hits.push_back(32'h700c);
    run_sweep("after_abort", 32'h7000, 32'h7010, 1'b0);

    // Simultaneous start and abort from FOUND: abort wins.
    exp_launch.delete();
    @(negedge clock); start = 1'b1; abort = 1'b1; nonce_base = 32'h0; nonce_limit = 32'hff;
    @(negedge clock); start = 1'b0; abort = 1'b0;
    chk("abort_prio", 256'({busy, hashSuccess, exhausted, ledControl, core_start}), 256'd0);
    @(negedge clock);
    chk("abort_prio:idle", 256'({busy, core_start}), 256'd0);

    for (int r = 0; r < 8; r++) begin
      hits.delete(); eqs.delete();
      cur_tgt = new_target();
      b = $urandom;
      if (r % 3 == 0) b = 32'hffff_ffff - 32'($urandom_range(20, 0));
      len = 32'($urandom_range(40, 0));
      l = ({32'd0, b} + {32'd0, len} > 64'h0000_0000_ffff_ffff) ? 32'hffff_ffff : b + len;
      for (int h = 0; h < int'($urandom_range(2, 0)); h++)
        hits.push_back(b + 32'($urandom_range(int'(l - b), 0)));
      eqs.push_back(b + 32'($urandom_range(int'(l - b), 0)));
      run_sweep("random", b, l, r[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
